phase_counter: RTL and testbench

//   Parametrised two-level phase counter for score-RAM management sequencing.
//   A prescaler counts DIV enabled clock cycles per step. The step counter

---
 rtl/phase_counter.sv | 147 ++++++++++++++
 tb/tb_phase_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
//
// Two-level phase counter that sequences the RAM access phases (address /
// read / write) of the NW score-matrix fill.
//
// A prescaler divides enabled clock cycles by DIV. Each time the prescaler
// completes, the step counter advances by one, from 0 up to LAST.
//
// On reaching LAST the counter behaves according to MODE:
//   MODE = 0  LAST is held for exactly one enabled cycle, and the counter then
//             restarts at 0. The period is LAST*DIV+1 enabled cycles.
//   MODE = 1  LAST is held until clr or rst. While LAST is held, en has no
//             effect.
//
// All three outputs are registered:
//   count   current step value
//   signal  high while count == LAST; updated on the same edge as count
//   tick    one-cycle pulse after every en-driven change of count
//
// Reset and clear are synchronous. Priority is rst > clr > en.
// ---------------------------------------------------------------------------
module phase_counter #(
  parameter int CNT_W = 4,
  parameter int DIV   = 3,
  parameter int LAST  = 2,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             signal,
  output logic             tick
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------

  // The prescaler is at least one bit wide, so that DIV = 1 still has a
  // legal register to hold.
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Terminal values, sized to the registers they are compared with.
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LAST);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  // One-shot behaviour is fixed at elaboration time.
  localparam bit ONE_SHOT = (MODE != 0);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  generate
    if (DIV < 1) begin : g_bad_div
      $error("phase_counter: DIV must be >= 1 (DIV=%0d)", DIV);
    end
    if (LAST < 1) begin : g_bad_last_lo
      $error("phase_counter: LAST must be >= 1 (LAST=%0d)", LAST);
    end
    if (LAST > (2 ** CNT_W) - 1) begin : g_bad_last_hi
      $error("phase_counter: LAST=%0d does not fit in CNT_W=%0d bits",
             LAST, CNT_W);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------

  // The prescaler stays internal; only count is visible at the ports.
  logic [PRE_W-1:0] pre;

  // Next-state values, produced by the combinational block below.
  logic [CNT_W-1:0] count_next;
  logic [PRE_W-1:0] pre_next;

  // Decoded conditions on the current state.
  logic             at_last;
  logic             pre_done;

  assign at_last  = (count == LAST_C);
  assign pre_done = (pre == PRE_MAX);

  // -------------------------------------------------------------------------
  // Next-state logic
  //
  // Computes where an enabled edge would take count and the prescaler.
  // rst and clr are handled in the register block, so they override
  // whatever is computed here.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a hold value first, so that branches which do
    // not assign it cannot infer a latch.
    count_next = count;
    pre_next   = pre;

    if (en) begin
      if (at_last) begin
        // LAST dwells for one enabled cycle. In wrap mode the counter then
        // restarts; in one-shot mode it stays at LAST.
        if (!ONE_SHOT) begin
          count_next = '0;
          pre_next   = '0;
        end
      end else if (pre_done) begin
        // The prescaler has completed a step: advance the step counter.
        // count < LAST here, so the increment cannot overflow CNT_W bits.
        count_next = count + 1'b1;
        pre_next   = '0;
      end else begin
        // Still part-way through a step.
        pre_next = pre + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  //
  // Updates count, the prescaler, signal and tick. rst and clr both discard
  // partial prescale progress, so the first step after release takes a full
  // DIV enabled cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before this edge.
      count  <= '0;
      pre    <= '0;
      signal <= 1'b0;
      tick   <= 1'b0;
    end else begin
      count  <= count_next;
      pre    <= pre_next;
      // signal follows the new count on the same edge, so it is registered
      // rather than a decode of the count output.
      signal <= (count_next == LAST_C);
      // tick pulses only on edges where en actually changes count,
      // including the wrap back to 0.
      tick   <= en && (count_next != count);
    end
  end

endmodule

// File: tb/tb_phase_counter.sv
// ---------------------------------------------------------------------------
// tb_phase_counter
//
// Three DUT instances share clk, rst, en and clr:
//   A  DIV=3, LAST=2, MODE=0  (wrap)
//   B  DIV=3, LAST=2, MODE=1  (one-shot)
//   C  DIV=1, LAST=5, MODE=0  (wrap, steps every enabled cycle)
//
// The reference model tracks a single phase index p, which counts enabled
// cycles since the last restart:
//   wrap mode      p advances modulo LAST*DIV+1
//   one-shot mode  p saturates at LAST*DIV
// From p, the expected outputs are
//   count  = p / DIV
//   signal = (count == LAST)
//   tick   = en-driven change of count
//
// Instance A is also compared with a hand-written vector table.
// ---------------------------------------------------------------------------
module tb_phase_counter;

  // -------------------------------------------------------------------------
  // Clock and DUT-facing signals
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst, en, clr;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       sig_a, sig_b, sig_c;
  logic       tck_a, tck_b, tck_c;

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Devices under test
  // -------------------------------------------------------------------------
  phase_counter #(.CNT_W(4), .DIV(3), .LAST(2), .MODE(0)) u_a (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .count  (cnt_a),
    .signal (sig_a),
    .tick   (tck_a)
  );

  phase_counter #(.CNT_W(4), .DIV(3), .LAST(2), .MODE(1)) u_b (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .count  (cnt_b),
    .signal (sig_b),
    .tick   (tck_b)
  );

  phase_counter #(.CNT_W(4), .DIV(1), .LAST(5), .MODE(0)) u_c (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .count  (cnt_c),
    .signal (sig_c),
    .tick   (tck_c)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: one phase index per instance
  // -------------------------------------------------------------------------
  int    m_div  [3] = '{3, 3, 1};
  int    m_last [3] = '{2, 2, 5};
  int    m_mode [3] = '{0, 1, 0};
  string m_name [3] = '{"A", "B", "C"};
  int    m_p    [3] = '{0, 0, 0};
  int    m_tick [3] = '{0, 0, 0};

  // Advances the model by one clock edge for the given inputs.
  function automatic void model_edge(input logic r, input logic e, input logic c);
    for (int i = 0; i < 3; i++) begin
      int old_cnt;
      int span;

      old_cnt = m_p[i] / m_div[i];
      span    = m_last[i] * m_div[i];

      if (r || c) begin
        m_p[i]    = 0;
        m_tick[i] = 0;
      end else if (e) begin
        if (m_mode[i] == 0) begin
          m_p[i] = (m_p[i] + 1) % (span + 1);
        end else if (m_p[i] < span) begin
          m_p[i] = m_p[i] + 1;
        end
        m_tick[i] = ((m_p[i] / m_div[i]) != old_cnt) ? 1 : 0;
      end else begin
        m_tick[i] = 0;
      end
    end
  endfunction

  // Compares every instance against the model.
  task automatic compare_model();
    int ac [3];
    int as [3];
    int at [3];

    ac = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
    as = '{int'(sig_a), int'(sig_b), int'(sig_c)};
    at = '{int'(tck_a), int'(tck_b), int'(tck_c)};

    for (int i = 0; i < 3; i++) begin
      int ec;
      ec = m_p[i] / m_div[i];
      check({m_name[i], " count"},  ac[i], ec);
      check({m_name[i], " signal"}, as[i], (ec == m_last[i]) ? 1 : 0);
      check({m_name[i], " tick"},   at[i], m_tick[i]);
    end
  endtask

  // Drives one cycle of inputs, then samples 1 ns after the edge.
  task automatic step(input logic r, input logic e, input logic c);
    rst = r;
    en  = e;
    clr = c;
    @(posedge clk);
    #1;
    model_edge(r, e, c);
    compare_model();
  endtask

  // -------------------------------------------------------------------------
  // Vector table for instance A: inputs, then expected outputs after the edge
  // -------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] cnt;
    logic       sig;
    logic       tck;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic c,
                              input logic [3:0] k, input logic s, input logic t);
    vec_t v;
    v.rst = r;
    v.en  = e;
    v.clr = c;
    v.cnt = k;
    v.sig = s;
    v.tck = t;
    tbl.push_back(v);
  endfunction

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;

    // Reset, then a first full wrap period: 0,0,1,1,1,2,0.
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1);
    add(0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 2, 1, 1);
    add(0, 1, 0, 0, 0, 1);

    // Two enabled cycles, then en low for 4 cycles: everything is frozen.
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, 0, 0, 0, 0, 0);
    end
    // Counting resumes where it stopped.
    add(0, 1, 0, 1, 0, 1);

    // rst with count=1 and prescaler=1, then a full DIV cycles to count=1.
    add(0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1);

    // rst and clr together give the same result as rst alone.
    add(0, 1, 0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);

    // clr on the edge where a step would occur: clr wins over en.
    add(0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1);

    // Reach LAST, then freeze there: signal holds and tick drops.
    add(0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 2, 1, 1);
    add(0, 0, 0, 2, 1, 0);
    add(0, 1, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].clr);
      check($sformatf("tbl[%0d] count", i),  int'(cnt_a), int'(tbl[i].cnt));
      check($sformatf("tbl[%0d] signal", i), int'(sig_a), int'(tbl[i].sig));
      check($sformatf("tbl[%0d] tick", i),   int'(tck_a), int'(tbl[i].tck));
    end

    // One-shot: B reaches LAST and holds it with en high.
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 0);
    end
    check("B hold count",  int'(cnt_b), 2);
    check("B hold signal", int'(sig_b), 1);
    check("B hold tick",   int'(tck_b), 0);

    // clr releases B, and B then counts again.
    step(0, 1, 1);
    check("B clr count",  int'(cnt_b), 0);
    check("B clr signal", int'(sig_b), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
    end
    check("B resume count", int'(cnt_b), 1);

    // DIV=1: C changes count on every enabled cycle, wrapping after 5.
    step(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0);
      check($sformatf("C dense tick %0d", i),  int'(tck_c), 1);
      check($sformatf("C dense count %0d", i), int'(cnt_c), (i + 1) % 6);
    end

    // Randomised traffic, checked against the model on every edge.
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic e;
      logic c;
      r = ($urandom_range(99) < 2);
      c = ($urandom_range(99) < 5);
      e = ($urandom_range(99) < 75);
      step(r, e, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
